// File: rtl/hms_time_if.sv
// Button inputs and time/status outputs of the HMS timekeeping core.
// master = board/top side that drives the buttons, slave = the core.
interface hms_time_if;
  logic       sw0;
  logic       sw1;
  logic       sw2;
  logic       mode;
  logic [1:0] position;
  logic [5:0] sec;
  logic [5:0] min;
  logic [4:0] hour;
  logic       sec_wrap;
  logic       min_wrap;
  logic       blink;

  modport master (
    output sw0, sw1, sw2,
    input  mode, position, sec, min, hour, sec_wrap, min_wrap, blink
  );

  modport slave (
    input  sw0, sw1, sw2,
    output mode, position, sec, min, hour, sec_wrap, min_wrap, blink
  );
endinterface

// File: rtl/hms_time_core.sv
// Single-clock hour:min:sec core: 1 Hz prescaler, strobe-sampled button debounce,
// CLOCK/SETUP mode FSM and field counters. All state advances on clk under enables.
module hms_time_core #(
  parameter int CLK_HZ   = 50_000_000,
  parameter int DEB_HZ   = 100,
  parameter int HOUR_MAX = 23
) (
  input  logic     clk,
  input  logic     rst_n,
  hms_time_if.slave bus
);
  localparam int DIV = CLK_HZ / DEB_HZ;
  localparam int CW  = $clog2(CLK_HZ);
  localparam int DW  = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(CLK_HZ - 1);
  localparam logic [CW-1:0] CNT_HALF = CW'(CLK_HZ / 2 - 1);
  localparam logic [DW-1:0] DEB_LAST = DW'(DIV - 1);
  localparam logic [4:0]    HMAX     = 5'(HOUR_MAX);
  localparam logic [1:0]    POS_SEC  = 2'd0;
  localparam logic [1:0]    POS_MIN  = 2'd1;
  localparam logic [1:0]    POS_HOUR = 2'd2;

  typedef enum logic {CLOCK = 1'b0, SETUP = 1'b1} mode_t;

  logic [CW-1:0] cnt, cnt_nx;
  logic          tick;
  logic [DW-1:0] dcnt;
  logic          strobe;
  logic [2:0]    sw_in, meta, sync, s1, s2, press;

  mode_t      st, st_nx;
  logic [1:0] pos, pos_nx;
  logic [5:0] sec, sec_nx, min, min_nx;
  logic [4:0] hour, hour_nx;
  logic       sec_wrap, sw_nx, min_wrap, mw_nx, blink, blink_nx;
  logic       sec_last, min_last;
  logic [5:0] sec_inc, min_inc;
  logic [4:0] hour_inc;

  assign tick   = (cnt == CNT_LAST);
  assign strobe = (dcnt == DEB_LAST);
  assign sw_in  = {bus.sw2, bus.sw1, bus.sw0};

  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) dcnt <= '0;
    else        dcnt <= strobe ? '0 : dcnt + 1'b1;

  // Buttons are active-low, so idle samples are 1; a press is a sampled 1 -> 0.
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      meta  <= '1;
      sync  <= '1;
      s1    <= '1;
      s2    <= '1;
      press <= '0;
    end else begin
      meta  <= sw_in;
      sync  <= meta;
      press <= '0;
      if (strobe) begin
        s1    <= sync;
        s2    <= s1;
        press <= s1 & ~sync;
      end
    end

  assign sec_last = (sec == 6'd59);
  assign min_last = (min == 6'd59);
  assign sec_inc  = sec_last ? 6'd0 : sec + 6'd1;
  assign min_inc  = min_last ? 6'd0 : min + 6'd1;
  assign hour_inc = (hour == HMAX) ? 5'd0 : hour + 5'd1;

  always_comb begin
    st_nx    = st;
    pos_nx   = pos;
    sec_nx   = sec;
    min_nx   = min;
    hour_nx  = hour;
    sw_nx    = 1'b0;
    mw_nx    = 1'b0;
    blink_nx = blink;
    cnt_nx   = tick ? '0 : cnt + 1'b1;
    case (st)
      CLOCK: begin
        if (press[0]) begin
          st_nx  = SETUP;
          pos_nx = POS_SEC;
        end else if (tick) begin
          sec_nx = sec_inc;
          if (sec_last) begin
            sw_nx  = 1'b1;
            min_nx = min_inc;
            if (min_last) begin
              mw_nx   = 1'b1;
              hour_nx = hour_inc;
            end
          end
        end
      end
      SETUP: begin
        if (tick || cnt == CNT_HALF) blink_nx = ~blink;
        // Exit restarts the second so the first count after setup is a full one.
        if (press[0]) begin
          st_nx    = CLOCK;
          cnt_nx   = '0;
          blink_nx = 1'b0;
        end else if (press[1]) begin
          pos_nx = (pos == POS_HOUR) ? POS_SEC : pos + 2'd1;
        end else if (press[2]) begin
          case (pos)
            POS_SEC: begin sec_nx = sec_inc; sw_nx = sec_last; end
            POS_MIN: begin min_nx = min_inc; mw_nx = min_last; end
            default: hour_nx = hour_inc;
          endcase
        end
      end
      default: st_nx = CLOCK;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      cnt      <= '0;
      st       <= CLOCK;
      pos      <= POS_SEC;
      sec      <= '0;
      min      <= '0;
      hour     <= '0;
      sec_wrap <= 1'b0;
      min_wrap <= 1'b0;
      blink    <= 1'b0;
    end else begin
      cnt      <= cnt_nx;
      st       <= st_nx;
      pos      <= pos_nx;
      sec      <= sec_nx;
      min      <= min_nx;
      hour     <= hour_nx;
      sec_wrap <= sw_nx;
      min_wrap <= mw_nx;
      blink    <= blink_nx;
    end

  assign bus.mode     = (st == SETUP);
  assign bus.position = pos;
  assign bus.sec      = sec;
  assign bus.min      = min;
  assign bus.hour     = hour;
  assign bus.sec_wrap = sec_wrap;
  assign bus.min_wrap = min_wrap;
  assign bus.blink    = blink;
endmodule
